// File: rtl/rfid_capture_writer.sv
// rfid_capture_writer
//   Packs a demodulated RFID byte stream into 32-bit little-endian words and
//   writes them through an Avalon-MM write master into the capture buffer.
//   Software programs base_addr/num_bytes and pulses start; done pulses once
//   the last word (or the in-flight word after an abort) has been accepted.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        one-cycle control pulses
//   base_addr           first word address (sampled on start)
//   num_bytes           bytes to capture (sampled on start)
//   in_data/in_valid/in_ready   byte stream, taken on in_valid & in_ready
//   avm_*               Avalon-MM write master (word addressed)
//   busy                capture in progress
//   done                one-cycle completion pulse
//   aborted             sticky: last capture ended by abort
//   words_written       words accepted by the memory in current/last capture
module rfid_capture_writer #(
    parameter int ADDR_W = 13,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bytes,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] word_idx;
    logic [23:0]       pack_data;
    logic [1:0]        pack_cnt;
    logic              pend_valid;

    logic              take, accept, word_done;
    logic              start_cap, finish, set_aborted, discard;
    logic [31:0]       word_new;
    logic [3:0]        be_new;

    // The pending slot is the write master; its outputs are registers, so
    // in_ready never depends combinationally on avm_waitrequest.
    assign avm_write      = pend_valid;
    assign avm_chipselect = pend_valid;
    assign busy           = (state != IDLE);

    // A byte that completes a word needs the slot free; other bytes only need
    // room in the pack register, so packing overlaps the outstanding write.
    assign in_ready = (state == CAPTURE) && (remaining != '0) &&
                      (((pack_cnt != 2'd3) && (remaining != CNT_W'(1))) || !pend_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_cap   = 1'b0;
        finish      = 1'b0;
        set_aborted = 1'b0;
        discard     = 1'b0;
        take        = in_valid && in_ready;
        accept      = pend_valid && !avm_waitrequest;
        word_done   = take && ((pack_cnt == 2'd3) || (remaining == CNT_W'(1)));
        // Unused upper lanes of pack_data are kept zero, so OR-ing the new
        // byte into its lane yields the zero-padded partial word directly.
        word_new    = {8'h00, pack_data} | (32'(in_data) << {pack_cnt, 3'b000});
        case (pack_cnt)
            2'd0:    be_new = 4'b0001;
            2'd1:    be_new = 4'b0011;
            2'd2:    be_new = 4'b0111;
            default: be_new = 4'b1111;
        endcase

        case (state)
            IDLE: begin
                if (start) begin
                    start_cap = 1'b1;
                    if (num_bytes == '0) finish = 1'b1;
                    else                 state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    discard = 1'b1;
                    if (pend_valid && !accept) begin
                        state_next = DRAIN;
                    end else begin
                        state_next  = IDLE;
                        finish      = 1'b1;
                        set_aborted = 1'b1;
                    end
                end else if ((remaining == '0) && (!pend_valid || accept)) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_next  = IDLE;
                    finish      = 1'b1;
                    set_aborted = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining      <= '0;
            base_q         <= '0;
            word_idx       <= '0;
            pack_data      <= '0;
            pack_cnt       <= '0;
            pend_valid     <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            avm_byteenable <= '0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            words_written  <= '0;
        end else begin
            done <= finish;

            if (accept) begin
                pend_valid    <= 1'b0;
                words_written <= words_written + (ADDR_W+1)'(1);
            end

            if (start_cap) begin
                base_q        <= base_addr;
                remaining     <= num_bytes;
                word_idx      <= '0;
                pack_data     <= '0;
                pack_cnt      <= '0;
                words_written <= '0;
                aborted       <= 1'b0;
            end

            if (set_aborted) aborted <= 1'b1;

            // Abort drops the partial word, including a byte handshaked in
            // the abort cycle itself.
            if (discard) begin
                pack_data <= '0;
                pack_cnt  <= '0;
            end else if (take) begin
                remaining <= remaining - CNT_W'(1);
                if (word_done) begin
                    pend_valid     <= 1'b1;
                    avm_writedata  <= word_new;
                    avm_byteenable <= be_new;
                    avm_address    <= base_q + word_idx;
                    word_idx       <= word_idx + ADDR_W'(1);
                    pack_data      <= '0;
                    pack_cnt       <= '0;
                end else begin
                    case (pack_cnt)
                        2'd0:    pack_data[7:0]   <= in_data;
                        2'd1:    pack_data[15:8]  <= in_data;
                        default: pack_data[23:16] <= in_data;
                    endcase
                    pack_cnt <= pack_cnt + 2'd1;
                end
            end
        end
    end

endmodule
